// File: rtl/psram_stream_reader_pkg.sv
// Shared memory-side definitions for the cellular RAM read/write paths.
package psram_stream_reader_pkg;

    localparam int unsigned MEM_ADDR_W          = 26;
    localparam int unsigned MEM_DATA_W          = 16;
    localparam int unsigned DEFAULT_WAIT_CYCLES = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_PRESENT = 2'd2
    } rd_state_e;

    // Active-low RAM control pair driven together during an access.
    typedef struct packed {
        logic cs_n;
        logic oe_n;
    } mem_ctrl_t;

endpackage

// File: rtl/psram_stream_reader_mem_wait_timer.sv
// Async-read wait timer: loaded on entry to ACCESS, flags the final access cycle.
module psram_stream_reader_mem_wait_timer #(
    parameter int unsigned WAIT_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic active,
    output logic expire_c
);

    localparam int unsigned CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES);

    logic [CNT_W-1:0] cnt_q;

    // Count down from WAIT_CYCLES-1; holds at zero until reloaded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= CNT_W'(WAIT_CYCLES - 1);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // Last cycle of the access window.
    always_comb begin
        expire_c = active && (cnt_q == '0);
    end

endmodule

// File: rtl/psram_stream_reader.sv
// Streaming reader for the 16-bit async cellular RAM.
// Optional feature macro: PSRAM_READER_LOOP_EN (restart at start_addr after the last word).
module psram_stream_reader
    import psram_stream_reader_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
    parameter int unsigned LEN_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [MEM_ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]      length,
    input  logic                  stop,
    input  logic                  loop_en,
    output logic [MEM_DATA_W-1:0] data_out,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  busy,
    output logic                  done,
    inout  wire  [MEM_DATA_W-1:0] MemDB,
    output logic [MEM_ADDR_W-1:0] MemAdr,
    output logic                  RamCS,
    output logic                  MemOE,
    output logic                  MemWR,
    output logic                  RamAdv,
    output logic                  RamClk,
    output logic                  RamLB,
    output logic                  RamUB
);

    rd_state_e             state_q, state_d;
    logic [MEM_ADDR_W-1:0] addr_q, addr_d;
    logic [MEM_ADDR_W-1:0] base_addr_q, base_addr_d;
    logic [LEN_W-1:0]      base_len_q, base_len_d;
    logic [LEN_W-1:0]      remain_q, remain_d;
    logic [MEM_DATA_W-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    mem_ctrl_t             ctrl_q, ctrl_d;
    logic                  load_c;
    logic                  expire_c;
    logic                  handshake_c;
    logic                  last_c;

`ifndef PSRAM_READER_LOOP_EN
    logic unused_loop_en;
    assign unused_loop_en = loop_en;
`endif

    // Read-only bus: this block never drives the RAM data lines.
    assign MemDB  = 16'bz;
    assign MemWR  = 1'b1;
    assign RamAdv = 1'b0;
    assign RamClk = 1'b0;
    assign RamLB  = 1'b0;
    assign RamUB  = 1'b0;

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign MemAdr     = addr_q;
    assign RamCS      = ctrl_q.cs_n;
    assign MemOE      = ctrl_q.oe_n;

    psram_stream_reader_mem_wait_timer #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load_c),
        .active   (state_q == ST_ACCESS),
        .expire_c (expire_c)
    );

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            base_addr_q <= '0;
            base_len_q  <= '0;
            remain_q    <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            ctrl_q      <= '{cs_n: 1'b1, oe_n: 1'b1};
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            base_addr_q <= base_addr_d;
            base_len_q  <= base_len_d;
            remain_q    <= remain_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            ctrl_q      <= ctrl_d;
        end
    end

    // Next-state and next-output logic; stop outranks capture and handshake.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        base_addr_d = base_addr_q;
        base_len_d  = base_len_q;
        remain_d    = remain_q;
        data_d      = data_q;
        valid_d     = valid_q;
        done_d      = 1'b0;
        handshake_c = valid_q && data_ready;
        last_c      = (remain_q == LEN_W'(1));

        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    if (length != '0) begin
                        base_addr_d = start_addr;
                        base_len_d  = length;
                        addr_d      = start_addr;
                        remain_d    = length;
                        state_d     = ST_ACCESS;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_ACCESS: begin
                if (stop) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (expire_c) begin
                    data_d  = MemDB;
                    valid_d = 1'b1;
                    state_d = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (stop) begin
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (handshake_c) begin
                    valid_d = 1'b0;
                    if (!last_c) begin
                        remain_d = remain_q - LEN_W'(1);
                        addr_d   = addr_q + MEM_ADDR_W'(1);
                        state_d  = ST_ACCESS;
`ifdef PSRAM_READER_LOOP_EN
                    end else if (loop_en) begin
                        remain_d = base_len_q;
                        addr_d   = base_addr_q;
                        state_d  = ST_ACCESS;
`endif
                    end else begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        load_c      = (state_d == ST_ACCESS) && (state_q != ST_ACCESS);
        busy_d      = (state_d != ST_IDLE);
        ctrl_d.cs_n = (state_d != ST_ACCESS);
        ctrl_d.oe_n = (state_d != ST_ACCESS);
    end

endmodule
